// File: rtl/cost_table_arbiter.sv
// Round-robin arbiter sharing one asynchronous-read cost table between NREQ requesters.
// Requesters may lock the table for a bounded burst; reads return with a fixed two-cycle latency.
module cost_table_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 3,
    parameter int CW      = 7,
    parameter int LOCKMAX = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   w_in,
    input  logic [NREQ*AW-1:0]   j_in,
    output logic [NREQ-1:0]      gnt,
    output logic [AW-1:0]        W,
    output logic [AW-1:0]        J,
    input  logic [CW-1:0]        Cost,
    output logic [CW-1:0]        rdata,
    output logic [NREQ-1:0]      rvalid
);

    localparam int PW = (NREQ > 2) ? 2 : 1;
    localparam int LW = 4;

    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [LW-1:0]   lcnt;
    logic [PW-1:0]   gnt_idx;
    logic            arb_hit;
    logic [PW:0]     sum_w;
    logic [PW-1:0]   tag;
    logic            tag_vld;
    logic            xfer;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + PW'(1);
    endfunction

    // Scanning the rotation from the far end down lets the candidate closest to ptr win.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        arb_hit = 1'b0;
        sum_w   = '0;
        if (!RST) begin
            if (state == LOCK) begin
                gnt_idx    = owner;
                gnt[owner] = req[owner];
            end else begin
                for (int o = NREQ - 1; o >= 0; o--) begin
                    sum_w = {1'b0, ptr} + (PW+1)'(o);
                    if (sum_w >= (PW+1)'(NREQ)) begin
                        sum_w = sum_w - (PW+1)'(NREQ);
                    end
                    if (req[sum_w[PW-1:0]]) begin
                        gnt_idx = sum_w[PW-1:0];
                        arb_hit = 1'b1;
                    end
                end
                if (arb_hit) begin
                    gnt[gnt_idx] = 1'b1;
                end
            end
        end
    end

    assign xfer = |(req & gnt);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ARB;
            ptr     <= '0;
            owner   <= '0;
            lcnt    <= '0;
            tag     <= '0;
            tag_vld <= 1'b0;
            W       <= '0;
            J       <= '0;
            rdata   <= '0;
            rvalid  <= '0;
        end else begin
            tag_vld <= xfer;
            if (xfer) begin
                tag <= gnt_idx;
                W   <= w_in[int'(gnt_idx)*AW +: AW];
                J   <= j_in[int'(gnt_idx)*AW +: AW];
            end

            // The table answers combinationally from W/J, so capture one cycle after the transfer.
            rvalid <= tag_vld ? (NREQ'(1) << tag) : '0;
            if (tag_vld) begin
                rdata <= Cost;
            end

            case (state)
                ARB: begin
                    if (xfer) begin
                        if (lock[gnt_idx] && LOCKMAX > 1) begin
                            state <= LOCK;
                            owner <= gnt_idx;
                            lcnt  <= LW'(1);
                        end else begin
                            ptr <= next_idx(gnt_idx);
                        end
                    end
                end
                LOCK: begin
                    // Tenure ends on a dropped lock bit or after LOCKMAX accepted transfers.
                    if (xfer) begin
                        if (!lock[owner] || lcnt == LW'(LOCKMAX - 1)) begin
                            state <= ARB;
                            ptr   <= next_idx(owner);
                            lcnt  <= '0;
                        end else begin
                            lcnt <= lcnt + LW'(1);
                        end
                    end else if (!lock[owner]) begin
                        state <= ARB;
                        ptr   <= next_idx(owner);
                        lcnt  <= '0;
                    end
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cost_table_arbiter.sv
// Bench for cost_table_arbiter: directed vector table, hand-written lock/pipeline/reset sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_cost_table_arbiter;

    localparam int NREQ    = 2;
    localparam int AW      = 3;
    localparam int CW      = 7;
    localparam int LOCKMAX = 8;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ-1:0]     lock = '0;
    logic [NREQ*AW-1:0]  w_in = '0;
    logic [NREQ*AW-1:0]  j_in = '0;
    logic [NREQ-1:0]     gnt;
    logic [AW-1:0]       W;
    logic [AW-1:0]       J;
    logic [CW-1:0]       Cost;
    logic [CW-1:0]       rdata;
    logic [NREQ-1:0]     rvalid;

    // Table contents: Cost = 8*W + J.
    assign Cost = {1'b0, W, J};

    cost_table_arbiter #(
        .NREQ(NREQ), .AW(AW), .CW(CW), .LOCKMAX(LOCKMAX)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .lock(lock), .w_in(w_in), .j_in(j_in),
        .gnt(gnt), .W(W), .J(J), .Cost(Cost), .rdata(rdata), .rvalid(rvalid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int tag;
        int cost;
    } ret_t;

    typedef struct {
        bit              rst;
        logic [1:0]      req;
        logic [1:0]      lock;
        logic [5:0]      w;
        logic [5:0]      j;
        logic [1:0]      gnt;
        logic [1:0]      rvalid;
        logic [6:0]      rdata;
    } vec_t;

    ret_t ret_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: owner = -1 means nobody holds the table.
    int   m_owner = -1;
    int   m_ptr = 0;
    int   m_tenure = 0;
    int   m_w = 0;
    int   m_j = 0;
    int   m_rdata = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [1:0] r);
        if (m_owner >= 0) return r[m_owner] ? m_owner : -1;
        for (int o = 0; o < NREQ; o++) begin
            if (r[(m_ptr + o) % NREQ]) return (m_ptr + o) % NREQ;
        end
        return -1;
    endfunction

    function automatic void model_release();
        m_ptr    = (m_owner + 1) % NREQ;
        m_owner  = -1;
        m_tenure = 0;
    endfunction

    task automatic applyReset();
        req  = '0;
        lock = '0;
        RST  = 1'b1;
        @(negedge CLK);
        checkOutput("rst gnt", 32'(gnt), 32'd0);
        checkOutput("rst W", 32'(W), 32'd0);
        checkOutput("rst J", 32'(J), 32'd0);
        checkOutput("rst rdata", 32'(rdata), 32'd0);
        checkOutput("rst rvalid", 32'(rvalid), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_owner  = -1;
        m_ptr    = 0;
        m_tenure = 0;
        m_w      = 0;
        m_j      = 0;
        m_rdata  = 0;
        ret_q.delete();
    endtask

    // One clock cycle: drive, check against the model at the falling edge, advance the model.
    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] l,
                                 input logic [5:0] wv, input logic [5:0] jv,
                                 output logic [1:0] g_obs, output logic [1:0] rv_obs,
                                 output logic [6:0] rd_obs);
        int         pick;
        logic [1:0] exp_gnt;
        logic [1:0] exp_rv;
        req  = r;
        lock = l;
        w_in = wv;
        j_in = jv;
        @(negedge CLK);
        pick    = model_pick(r);
        exp_gnt = (pick >= 0) ? 2'(1 << pick) : 2'b00;
        exp_rv  = 2'b00;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            exp_rv  = 2'(1 << ret_q[0].tag);
            m_rdata = ret_q[0].cost;
            void'(ret_q.pop_front());
        end
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("W", 32'(W), 32'(m_w));
        checkOutput("J", 32'(J), 32'(m_j));
        checkOutput("rvalid", 32'(rvalid), 32'(exp_rv));
        checkOutput("rdata", 32'(rdata), 32'(m_rdata));
        g_obs  = gnt;
        rv_obs = rvalid;
        rd_obs = rdata;

        if (pick >= 0) begin
            m_w = int'(wv[pick*AW +: AW]);
            m_j = int'(jv[pick*AW +: AW]);
            ret_q.push_back('{cyc + 2, pick, 8 * m_w + m_j});
        end
        if (m_owner < 0) begin
            if (pick >= 0) begin
                if (l[pick] && LOCKMAX > 1) begin
                    m_owner  = pick;
                    m_tenure = 1;
                end else begin
                    m_ptr = (pick + 1) % NREQ;
                end
            end
        end else if (pick >= 0) begin
            if (!l[m_owner] || m_tenure + 1 == LOCKMAX) model_release();
            else m_tenure++;
        end else if (!l[m_owner]) begin
            model_release();
        end

        @(posedge CLK);
        #1;
        cyc++;
    endtask

    function automatic vec_t mk(input bit rst, input logic [1:0] r, input logic [1:0] l,
                                input logic [5:0] w, input logic [5:0] j, input logic [1:0] g,
                                input logic [1:0] rv, input logic [6:0] rd);
        vec_t v;
        v.rst = rst; v.req = r; v.lock = l; v.w = w; v.j = j;
        v.gnt = g; v.rvalid = rv; v.rdata = rd;
        return v;
    endfunction

    initial begin
        logic [1:0] g;
        logic [1:0] rv;
        logic [6:0] rd;
        logic [1:0] fr_gnt [13];
        logic [1:0] pending;
        logic [2:0] cur_w [2];
        logic [2:0] cur_j [2];
        logic [1:0] r_req;
        logic [1:0] r_lock;

        // Single read, fairness, early release; w/j are packed {requester1, requester0}.
        vecs.push_back(mk(1, 2'b01, 2'b00, {3'd0, 3'd3}, {3'd0, 3'd5}, 2'b01, 2'b00, 7'd0));
        vecs.push_back(mk(0, 2'b00, 2'b00, {3'd0, 3'd3}, {3'd0, 3'd5}, 2'b00, 2'b00, 7'd0));
        vecs.push_back(mk(0, 2'b00, 2'b00, {3'd0, 3'd3}, {3'd0, 3'd5}, 2'b00, 2'b01, 7'd29));
        vecs.push_back(mk(1, 2'b11, 2'b00, {3'd2, 3'd1}, {3'd0, 3'd0}, 2'b01, 2'b00, 7'd0));
        vecs.push_back(mk(0, 2'b11, 2'b00, {3'd2, 3'd1}, {3'd0, 3'd0}, 2'b10, 2'b00, 7'd0));
        vecs.push_back(mk(0, 2'b11, 2'b00, {3'd2, 3'd1}, {3'd0, 3'd0}, 2'b01, 2'b01, 7'd8));
        vecs.push_back(mk(0, 2'b11, 2'b00, {3'd2, 3'd1}, {3'd0, 3'd0}, 2'b10, 2'b10, 7'd16));
        vecs.push_back(mk(0, 2'b00, 2'b00, {3'd2, 3'd1}, {3'd0, 3'd0}, 2'b00, 2'b01, 7'd8));
        vecs.push_back(mk(0, 2'b00, 2'b00, {3'd2, 3'd1}, {3'd0, 3'd0}, 2'b00, 2'b10, 7'd16));
        vecs.push_back(mk(0, 2'b00, 2'b00, {3'd2, 3'd1}, {3'd0, 3'd0}, 2'b00, 2'b00, 7'd16));
        vecs.push_back(mk(1, 2'b11, 2'b01, {3'd0, 3'd1}, {3'd2, 3'd1}, 2'b01, 2'b00, 7'd0));
        vecs.push_back(mk(0, 2'b11, 2'b01, {3'd0, 3'd1}, {3'd2, 3'd1}, 2'b01, 2'b00, 7'd0));
        vecs.push_back(mk(0, 2'b11, 2'b01, {3'd0, 3'd1}, {3'd2, 3'd1}, 2'b01, 2'b01, 7'd9));
        vecs.push_back(mk(0, 2'b11, 2'b00, {3'd0, 3'd1}, {3'd2, 3'd1}, 2'b01, 2'b01, 7'd9));
        vecs.push_back(mk(0, 2'b11, 2'b00, {3'd0, 3'd1}, {3'd2, 3'd1}, 2'b10, 2'b01, 7'd9));
        vecs.push_back(mk(0, 2'b00, 2'b00, {3'd0, 3'd1}, {3'd2, 3'd1}, 2'b00, 2'b01, 7'd9));
        vecs.push_back(mk(0, 2'b00, 2'b00, {3'd0, 3'd1}, {3'd2, 3'd1}, 2'b00, 2'b10, 7'd2));

        applyReset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) applyReset();
            applyStimulus(vecs[i].req, vecs[i].lock, vecs[i].w, vecs[i].j, g, rv, rd);
            checkOutput("vec gnt", 32'(g), 32'(vecs[i].gnt));
            checkOutput("vec rvalid", 32'(rv), 32'(vecs[i].rvalid));
            checkOutput("vec rdata", 32'(rd), 32'(vecs[i].rdata));
        end

        // Forced release after LOCKMAX grants, re-lock, idle inside tenure, then release.
        for (int n = 0; n < 8; n++) fr_gnt[n] = 2'b01;
        fr_gnt[8]  = 2'b10;
        fr_gnt[9]  = 2'b01;
        fr_gnt[10] = 2'b00;
        fr_gnt[11] = 2'b00;
        fr_gnt[12] = 2'b10;
        applyReset();
        for (int n = 0; n < 13; n++) begin
            applyStimulus((n < 10) ? 2'b11 : 2'b10, (n < 11) ? 2'b01 : 2'b00,
                          {3'd4, 3'd2}, {3'd1, 3'd6}, g, rv, rd);
            checkOutput("forced gnt", 32'(g), 32'(fr_gnt[n]));
        end

        // Back-to-back reads from requester 1.
        applyReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k < 8) ? 2'b10 : 2'b00, 2'b00, {3'(k), 3'd0}, {3'(7 - k), 3'd0},
                          g, rv, rd);
            checkOutput("pipe gnt", 32'(g), (k < 8) ? 32'd2 : 32'd0);
            if (k >= 2) begin
                checkOutput("pipe rvalid", 32'(rv), 32'd2);
                checkOutput("pipe rdata", 32'(rd), 32'(7 * (k - 1)));
            end
        end

        // Reset mid-burst with reads in flight and a lock held.
        applyReset();
        applyStimulus(2'b01, 2'b01, {3'd0, 3'd5}, {3'd0, 3'd2}, g, rv, rd);
        applyStimulus(2'b01, 2'b01, {3'd0, 3'd6}, {3'd0, 3'd3}, g, rv, rd);
        applyReset();
        applyStimulus(2'b11, 2'b00, {3'd1, 3'd1}, {3'd1, 3'd1}, g, rv, rd);
        checkOutput("post-rst gnt", 32'(g), 32'd1);
        checkOutput("post-rst rvalid", 32'(rv), 32'd0);
        applyStimulus(2'b00, 2'b00, {3'd1, 3'd1}, {3'd1, 3'd1}, g, rv, rd);
        checkOutput("post-rst rvalid2", 32'(rv), 32'd0);

        // Randomized traffic; a requester keeps its address while it waits for a grant.
        applyReset();
        pending = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cur_w[i] = 3'($urandom);
            cur_j[i] = 3'($urandom);
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pending[i]) begin
                    cur_w[i] = 3'($urandom);
                    cur_j[i] = 3'($urandom);
                end
            end
            r_req  = 2'($urandom);
            r_lock = 2'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            applyStimulus(r_req, r_lock, {cur_w[1], cur_w[0]}, {cur_j[1], cur_j[0]}, g, rv, rd);
            pending = r_req & ~g;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cost_table_arbiter.md
# cost_table_arbiter

Round-robin arbiter that shares one asynchronous-read cost table (the W/J → Cost job-assignment table) between up to four requesters, such as parallel permutation-evaluation engines. Each requester issues single (W, J) reads with a valid/grant handshake and may lock the table for a burst, for example the eight reads of one permutation. The block registers the address, captures Cost, and returns it to the owning requester with fixed latency and one-read-per-cycle throughput.

## Interface
- NREQ, 2, number of requesters (2..4)
- AW, 3, worker/job index width
- CW, 7, cost width
- LOCKMAX, 8, maximum accepted transfers per lock tenure (1..15)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  NREQ  read request per requester
- lock  in  NREQ  request exclusive tenure starting or continuing with this transfer
- w_in  in  NREQ*AW  worker index; requester i at bits [i*AW +: AW]
- j_in  in  NREQ*AW  job index, same packing
- gnt  out  NREQ  combinational one-hot grant; a transfer happens at the rising edge where req[i]&gnt[i]
- W  out  AW  registered worker index to the cost table
- J  out  AW  registered job index to the cost table
- Cost  in  CW  table read data, valid in the same cycle as W/J
- rdata  out  CW  registered Cost, broadcast to all requesters
- rvalid  out  NREQ  one-hot, qualifies rdata for its owner

## Operation
- State: ARB (no owner) or LOCK (owner k). Also a rotating pointer ptr (0..NREQ-1) and a lock counter lcnt (0..LOCKMAX).
- ARB: gnt is one-hot on the first requester with req high, searching ptr, ptr+1, … modulo NREQ. gnt is 0 if no req is high.
- LOCK: gnt[k] = req[k]. All other gnt bits are 0, and other requests wait.
- On an accepted transfer by i:
  - W <= w_in[i], J <= j_in[i].
  - The owner tag i is pipelined for rvalid.
- ARB transitions on a transfer by i:
  - lock[i]=1 and LOCKMAX>1: go to LOCK with k=i, lcnt=1.
  - Otherwise: stay in ARB, ptr <= i+1 (mod NREQ).
- LOCK transitions on a transfer by k:
  - lock[k]=0: go to ARB, ptr <= k+1.
  - lcnt+1 == LOCKMAX: forced release to ARB, ptr <= k+1, even if lock[k] is still 1. The owner must re-arbitrate.
  - Otherwise: lcnt <= lcnt+1.
- LOCK with no transfer: if lock[k]=0, go to ARB with ptr <= k+1. If lock[k]=1, hold the state even while req[k]=0, because the owner may idle inside its tenure.
- Data return: one cycle after a transfer, W/J present the address. At the next edge, rdata <= Cost and rvalid <= onehot(tag). Without a transfer, rvalid <= 0 and rdata holds its value.
- Arithmetic: the pointer wraps modulo NREQ, not modulo 2^width. lcnt never exceeds LOCKMAX.

## Timing
- Reset values:
  - W=0, J=0, rdata=0, rvalid=0.
  - State ARB, ptr=0, lcnt=0, no tag in flight.
  - gnt=0 while RST is high.
- Latency: transfer accepted in cycle c0; W/J valid in c1; rdata/rvalid valid in c2. Throughput is one read per cycle, back-to-back, with no bubbles.
- The requester must hold w_in/j_in stable while req is high and gnt is low. It may change them in the cycle after its transfer.
- Simultaneous requests in ARB: the lowest index at or after ptr wins. The loser's req stays pending.
- Lock is evaluated only with the owner's own transfer or its idle lock bit. lock bits of non-owners are ignored in LOCK.
- W/J hold their last value when no transfer occurs.
- Reset mid-operation: in-flight reads are dropped, no rvalid is produced afterwards, and any lock is cleared.

## Test plan
- Reset: assert RST mid-burst with a read in flight → all outputs 0 in the next cycle. No rvalid appears after release. The first grant goes to requester 0 when both request.
- Single read: table Cost = 8*W+J. req[0] with W=3, J=5 in c0 → gnt=01 in c0, W=3/J=5 in c1, rvalid=01 and rdata=29 in c2.
- Fairness: req=11 continuously with lock=00 → gnt sequence 01,10,01,10. rvalid follows the same sequence two cycles later.
- Forced release: req=11, lock[0]=1 constantly → eight consecutive grants to 0, then grant to 1, then 0 re-enters LOCK.
- Early release: lock[0]=1 for three transfers, then 0 on the fourth → four grants to 0, then gnt=10 in the next cycle.
- Pipeline: requester 1 issues W=0..7, J=7-W, on back-to-back cycles → eight contiguous rvalid=10 pulses with rdata 7,14,21,28,35,42,49,56.
